nios2_ocimem_jtag_sequencer: RTL and testbench

- Sysclk-domain controller that turns the JTAG debug module's decoded command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a plus jdo) into sequenced accesses on the on-chip debug memory (ocimem) port.
- Owns the auto-incrementing monitor address register, readback data register, ready/error status and a waitrequest timeout watchdog.
- Sits between the jtag_debug_module sysclk half and the ocimem RAM/Avalon slave.

---
 rtl/nios2_ocimem_pkg.sv | 19 +
 rtl/nios2_ocimem_timeout.sv | 32 +++
 rtl/nios2_ocimem_jtag_sequencer.sv | 166 ++++++++++++++++
 tb/tb_nios2_ocimem_jtag_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_ocimem_pkg.sv
// Shared definitions for the ocimem JTAG sequencer: FSM states, jdo field
// positions and the default waitrequest watchdog limit.
package nios2_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_REQ  = 2'd3
    } ocimem_state_t;

    localparam int JDO_ADDR_LOAD_BIT = 35;
    localparam int JDO_READ_BIT      = 34;
    localparam int JDO_ADDR_LSB      = 17;
    localparam int JDO_WDATA_LSB     = 3;

    localparam int DEFAULT_TIMEOUT   = 255;

endpackage

// File: rtl/nios2_ocimem_timeout.sv
// Saturating counter of consecutive stall cycles. The expired flag is high
// during the stall cycle that brings the count to TIMEOUT, so the caller can
// abort on that same edge. TIMEOUT = 0 disables expiry entirely.
module nios2_ocimem_timeout
    import nios2_ocimem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // Count stall cycles already completed; hold at LAST instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/nios2_ocimem_jtag_sequencer.sv
// Turns decoded JTAG debug strobes into single ocimem read/write accesses,
// keeping the auto-incrementing monitor address, readback data, status flags
// and a waitrequest watchdog.
module nios2_ocimem_jtag_sequencer
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic              debugack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    ocimem_state_t     state, state_next;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       rdata_next;
    logic [31:0]       wdata_next;
    logic              ready_next;
    logic              error_next;
    logic              any_strobe;
    logic              stall;
    logic              expired;
    logic              unused_jdo;

    // Only some jdo fields are decoded; fold the rest so they count as read.
    assign unused_jdo  = ^jdo;

    assign busy        = (state != ST_IDLE);
    assign mem_address = MonAReg;
    assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign stall       = mem_waitrequest && ((state == ST_RD_REQ) || (state == ST_WR_REQ));

    nios2_ocimem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!stall),
        .enable  (stall),
        .expired (expired)
    );

    // Command decode in IDLE, access sequencing, and drop/abort error handling.
    always_comb begin
        state_next = state;
        addr_next  = MonAReg;
        rdata_next = MonDReg;
        wdata_next = mem_writedata;
        ready_next = monitor_ready;
        error_next = monitor_error;

        case (state)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    if (jdo[JDO_ADDR_LOAD_BIT]) begin
                        addr_next  = jdo[JDO_ADDR_LSB +: ADDR_W];
                        error_next = 1'b0;
                    end else if (jdo[JDO_READ_BIT]) begin
                        if (debugack) begin
                            state_next = ST_RD_REQ;
                            ready_next = 1'b0;
                        end else begin
                            error_next = 1'b1;
                        end
                    end else if (!debugack) begin
                        error_next = 1'b1;
                    end
                    if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                        error_next = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    if (debugack) begin
                        state_next = ST_WR_REQ;
                        wdata_next = jdo[JDO_WDATA_LSB +: 32];
                        ready_next = 1'b0;
                    end else begin
                        error_next = 1'b1;
                    end
                    if (take_no_action_ocimem_a) begin
                        error_next = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    if (debugack) begin
                        state_next = ST_RD_REQ;
                        ready_next = 1'b0;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (expired) begin
                    state_next = ST_IDLE;
                    error_next = 1'b1;
                    ready_next = 1'b1;
                end else if (!mem_waitrequest) begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rdata_next = mem_readdata;
                addr_next  = MonAReg + ADDR_W'(1);
                ready_next = 1'b1;
                state_next = ST_IDLE;
            end
            ST_WR_REQ: begin
                if (expired) begin
                    state_next = ST_IDLE;
                    error_next = 1'b1;
                    ready_next = 1'b1;
                end else if (!mem_waitrequest) begin
                    addr_next  = MonAReg + ADDR_W'(1);
                    ready_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (busy && any_strobe) begin
            error_next = 1'b1;
        end
    end

    // State and status registers; requests are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            mem_writedata <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
        end else begin
            state         <= state_next;
            MonAReg       <= addr_next;
            MonDReg       <= rdata_next;
            mem_writedata <= wdata_next;
            monitor_ready <= ready_next;
            monitor_error <= error_next;
            mem_read      <= (state_next == ST_RD_REQ);
            mem_write     <= (state_next == ST_WR_REQ);
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_jtag_sequencer.sv
// Directed bench for the ocimem JTAG sequencer. One instance uses the default
// watchdog limit, a second uses TIMEOUT=4 for the watchdog scenario.
module tb_nios2_ocimem_jtag_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        debugack = 1'b1;
    logic [31:0] mem_readdata = 32'hBAD0BAD0;

    logic        a_m = 1'b0, b_m = 1'b0, na_m = 1'b0, wait_m = 1'b0;
    logic [7:0]  mem_address, mon_a;
    logic        mem_read, mem_write, ready, error, busy;
    logic [31:0] mem_wdata, mon_d;

    logic        a_t = 1'b0, b_t = 1'b0, na_t = 1'b0, wait_t = 1'b0;
    logic [7:0]  t_mem_address, t_mon_a;
    logic        t_mem_read, t_mem_write, t_ready, t_error, t_busy;
    logic [31:0] t_mem_wdata, t_mon_d;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nios2_ocimem_jtag_sequencer #(.ADDR_W(8), .TIMEOUT(255)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (a_m),
        .take_action_ocimem_b    (b_m),
        .take_no_action_ocimem_a (na_m),
        .jdo                     (jdo),
        .debugack                (debugack),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_wdata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (wait_m),
        .MonAReg                 (mon_a),
        .MonDReg                 (mon_d),
        .monitor_ready           (ready),
        .monitor_error           (error),
        .busy                    (busy)
    );

    nios2_ocimem_jtag_sequencer #(.ADDR_W(8), .TIMEOUT(4)) dut_to (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (a_t),
        .take_action_ocimem_b    (b_t),
        .take_no_action_ocimem_a (na_t),
        .jdo                     (jdo),
        .debugack                (debugack),
        .mem_address             (t_mem_address),
        .mem_read                (t_mem_read),
        .mem_write               (t_mem_write),
        .mem_writedata           (t_mem_wdata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (wait_t),
        .MonAReg                 (t_mon_a),
        .MonDReg                 (t_mon_d),
        .monitor_ready           (t_ready),
        .monitor_error           (t_error),
        .busy                    (t_busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [37:0] jdoAddr(input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[35] = 1'b1;
        j[17 +: 8] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdoRead();
        logic [37:0] j;
        j = '0;
        j[34] = 1'b1;
        return j;
    endfunction

    function automatic logic [37:0] jdoWrite(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // Present one strobe cycle at a negedge; returns at the negedge after E0.
    task automatic applyStimulus(input bit to_sel, input bit a, input bit b, input bit na,
                                 input logic [37:0] j);
        jdo = j;
        if (to_sel) begin
            a_t = a; b_t = b; na_t = na;
        end else begin
            a_m = a; b_m = b; na_m = na;
        end
        tick();
        a_m = 1'b0; b_m = 1'b0; na_m = 1'b0;
        a_t = 1'b0; b_t = 1'b0; na_t = 1'b0;
        jdo = '0;
    endtask

    // Unstalled read; read data is presented only in the cycle after acceptance.
    task automatic readWord(input bit to_sel, input bit use_a, input logic [7:0] addr,
                            input logic [31:0] data, input string tag);
        logic [7:0] nxt;
        nxt = addr + 8'd1;
        applyStimulus(to_sel, use_a, 1'b0, !use_a, use_a ? jdoRead() : 38'd0);
        checkOutput({tag, " req"},  to_sel ? t_mem_read : mem_read, 1);
        checkOutput({tag, " addr"}, to_sel ? t_mem_address : mem_address, addr);
        checkOutput({tag, " rdy0"}, to_sel ? t_ready : ready, 0);
        tick();
        checkOutput({tag, " reqoff"}, to_sel ? t_mem_read : mem_read, 0);
        checkOutput({tag, " rdy1"},   to_sel ? t_ready : ready, 0);
        mem_readdata = data;
        tick();
        mem_readdata = 32'hBAD0BAD0;
        checkOutput({tag, " data"},  to_sel ? t_mon_d : mon_d, data);
        checkOutput({tag, " ainc"},  to_sel ? t_mon_a : mon_a, nxt);
        checkOutput({tag, " ready"}, to_sel ? t_ready : ready, 1);
        checkOutput({tag, " idle"},  to_sel ? t_busy : busy, 0);
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst monA",  mon_a, 0);
        checkOutput("rst monD",  mon_d, 0);
        checkOutput("rst ready", ready, 1);
        checkOutput("rst error", error, 0);
        checkOutput("rst busy",  busy, 0);
        checkOutput("rst rd",    mem_read, 0);
        checkOutput("rst wr",    mem_write, 0);
        checkOutput("rst t rdy", t_ready, 1);
        reset_n = 1'b1;

        // Address load then plain read at 0x05.
        applyStimulus(0, 1, 0, 0, jdoAddr(8'h05));
        checkOutput("ld5 monA",  mon_a, 8'h05);
        checkOutput("ld5 ready", ready, 1);
        checkOutput("ld5 busy",  busy, 0);
        readWord(0, 1, 8'h05, 32'hDEADBEEF, "rd5");

        // Write with four stall cycles.
        wait_m = 1'b1;
        applyStimulus(0, 0, 1, 0, jdoWrite(32'h12345678));
        for (int i = 0; i < 5; i++) begin
            wait_m = (i < 4);
            checkOutput("wr hold", mem_write, 1);
            checkOutput("wr data", mem_wdata, 32'h12345678);
            checkOutput("wr addr", mem_address, 8'h06);
            checkOutput("wr rdy0", ready, 0);
            checkOutput("wr nord", mem_read, 0);
            tick();
        end
        checkOutput("wr done",  mem_write, 0);
        checkOutput("wr ready", ready, 1);
        checkOutput("wr ainc",  mon_a, 8'h07);
        checkOutput("wr idle",  busy, 0);

        // Address wrap and back-to-back streaming reads.
        applyStimulus(0, 1, 0, 0, jdoAddr(8'hFF));
        readWord(0, 0, 8'hFF, 32'hCAFE00FF, "strFF");
        readWord(0, 0, 8'h00, 32'hCAFE0000, "str00");
        readWord(0, 0, 8'h01, 32'hCAFE0001, "str01");

        // Strobe while busy is dropped.
        wait_m = 1'b1;
        applyStimulus(0, 1, 0, 0, jdoRead());
        applyStimulus(0, 0, 1, 0, jdoWrite(32'h00000055));
        checkOutput("busy err",   error, 1);
        checkOutput("busy nowr",  mem_write, 0);
        checkOutput("busy rd",    mem_read, 1);
        checkOutput("busy wdata", mem_wdata, 32'h12345678);
        wait_m = 1'b0;
        tick();
        mem_readdata = 32'hCAFE0002;
        tick();
        mem_readdata = 32'hBAD0BAD0;
        checkOutput("busy rdata", mon_d, 32'hCAFE0002);
        checkOutput("busy ainc",  mon_a, 8'h03);
        checkOutput("busy err2",  error, 1);

        // Address load clears the error.
        applyStimulus(0, 1, 0, 0, jdoAddr(8'h10));
        checkOutput("clr err",  error, 0);
        checkOutput("clr monA", mon_a, 8'h10);

        // A read together with B: A wins, B dropped with error.
        applyStimulus(0, 1, 1, 0, jdoRead() | jdoWrite(32'h00000099));
        checkOutput("ab rd",   mem_read, 1);
        checkOutput("ab nowr", mem_write, 0);
        checkOutput("ab err",  error, 1);
        tick();
        mem_readdata = 32'hCAFE0010;
        tick();
        mem_readdata = 32'hBAD0BAD0;
        checkOutput("ab rdata", mon_d, 32'hCAFE0010);
        checkOutput("ab ainc",  mon_a, 8'h11);

        // Read while the CPU is not in debug is dropped; address load is not.
        applyStimulus(0, 1, 0, 0, jdoAddr(8'h11));
        debugack = 1'b0;
        applyStimulus(0, 0, 0, 1, 38'd0);
        checkOutput("nodbg busy",  busy, 0);
        checkOutput("nodbg rd",    mem_read, 0);
        checkOutput("nodbg err",   error, 1);
        checkOutput("nodbg ready", ready, 1);
        checkOutput("nodbg monA",  mon_a, 8'h11);
        applyStimulus(0, 1, 0, 0, jdoAddr(8'h40));
        checkOutput("nodbg ld",    mon_a, 8'h40);
        checkOutput("nodbg clr",   error, 0);
        debugack = 1'b1;

        // Watchdog with TIMEOUT=4 on the second instance.
        applyStimulus(1, 1, 0, 0, jdoAddr(8'h20));
        readWord(1, 1, 8'h20, 32'h00000077, "to pre");
        wait_t = 1'b1;
        applyStimulus(1, 1, 0, 0, jdoRead());
        for (int i = 0; i < 4; i++) begin
            checkOutput("to stall", t_mem_read, 1);
            checkOutput("to busy",  t_busy, 1);
            tick();
        end
        checkOutput("to rdoff", t_mem_read, 0);
        checkOutput("to idle",  t_busy, 0);
        checkOutput("to err",   t_error, 1);
        checkOutput("to ready", t_ready, 1);
        checkOutput("to monA",  t_mon_a, 8'h21);
        checkOutput("to monD",  t_mon_d, 32'h00000077);
        wait_t = 1'b0;
        applyStimulus(1, 1, 0, 0, jdoAddr(8'h22));
        checkOutput("to clr",   t_error, 0);

        // Reset in the middle of a stalled read.
        wait_m = 1'b1;
        applyStimulus(0, 1, 0, 0, jdoRead());
        checkOutput("mr rd", mem_read, 1);
        reset_n = 1'b0;
        tick();
        checkOutput("mr rdoff", mem_read, 0);
        checkOutput("mr busy",  busy, 0);
        checkOutput("mr ready", ready, 1);
        checkOutput("mr monA",  mon_a, 0);
        checkOutput("mr monD",  mon_d, 0);
        checkOutput("mr err",   error, 0);
        reset_n = 1'b1;
        wait_m = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
